// File: rtl/ripple8_mpadd_ctrl_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
// Holds the controller state encoding and the byte-index width helper.
package ripple8_mpadd_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-bit index still covers the two-byte case, where $clog2 would give 1 anyway.
  function automatic int idx_width(input int nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/ripple8_mpadd_ctrl_ripple8.sv
// Purely combinational 8-bit ripple-carry adder, one full adder per bit.
// No state and no flow control; the controller owns all sequencing.
module ripple8
  import ripple8_mpadd_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_ci,
  output logic [BYTE_W-1:0] o_s,
  output logic              o_co
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < BYTE_W; g++) begin : g_fa
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_co = w_c[BYTE_W];

endmodule

// File: rtl/ripple8_mpadd_ctrl.sv
// Multi-precision add/subtract: one byte per cycle through a shared ripple8, LSB first.
// Result held in DONE until consumed; no new request is accepted until then.
module ripple8_mpadd_ctrl
  import ripple8_mpadd_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_a,
  input  logic [BYTE_W*NBYTES-1:0] in_b,
  input  logic                     in_sub,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_sum,
  output logic                     out_co,
  output logic                     out_ovf
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic              r_co;
  logic              r_ovf;

  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_s;
  logic              w_co;

  assign w_a_byte = r_a[BYTE_W*r_idx +: BYTE_W];
  assign w_b_byte = r_b[BYTE_W*r_idx +: BYTE_W];

  ripple8 u_ripple8 (
    .i_a  (w_a_byte),
    .i_b  (w_b_byte),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = (r_idx == LAST_IDX);
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1, so the inversion and forced carry happen at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_sub ? ~in_b : in_b;
      r_carry <= in_sub | in_cin;
      r_idx   <= '0;
    end else if (w_step) begin
      r_sum[BYTE_W*r_idx +: BYTE_W] <= w_s;
      r_carry <= w_co;
      if (w_last) begin
        r_idx <= '0;
        r_co  <= w_co;
        r_ovf <= (r_a[W-1] == r_b[W-1]) & (w_s[BYTE_W-1] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_co    = r_co;
  assign out_ovf   = r_ovf;

endmodule
